// File: rtl/antilog_decode_pkg.sv
// Shared widths and constants for the antilog decode stage of the log-domain multiplier.
package antilog_decode_pkg;
  localparam int CHAR_W   = 5;
  localparam int FRAC_W   = 15;
  localparam int PROD_W   = 32;
  localparam int CHAR_SAT = 31;
  localparam int ONEHOT_W = CHAR_SAT;
  localparam int V_W      = FRAC_W + 1;
  // Widest shifted mantissa: V << 30 needs V_W + 30 bits; one spare keeps the slice aligned.
  localparam int SHIFT_W  = V_W + CHAR_SAT;

  localparam logic [PROD_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [ONEHOT_W-1:0] sel;
    logic [FRAC_W-1:0]   frac;
    logic                zero;
    logic                sat;
  } s1_t;
endpackage

// File: rtl/antilog_decode_char_decode.sv
// Characteristic code to one-hot shift select; code 31 decodes to all-zero.
module char_decode
  import antilog_decode_pkg::*;
(
  input  logic [CHAR_W-1:0]   code,
  output logic [ONEHOT_W-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int k = 0; k < ONEHOT_W; k++)
      onehot[k] = (code == CHAR_W'(k));
  end
endmodule

// File: rtl/antilog_decode.sv
// Two-stage antilog: S1 decodes characteristic to one-hot, S2 shifts {1,frac} into the product.
module antilog_decode
  import antilog_decode_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              out_sat
);
  s1_t                 s1;
  logic                s1_valid, s2_valid, s2_adv;
  logic [ONEHOT_W-1:0] sel_d;
  logic [SHIFT_W-1:0]  acc;
  logic [PROD_W-1:0]   prod_d;
  logic                sat_d;

  char_decode u_dec (.code(in_char), .onehot(sel_d));

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // One-hot select makes the barrel shift an AND-OR tree; dropping the low FRAC_W bits truncates.
  always_comb begin
    acc = '0;
    for (int k = 0; k < ONEHOT_W; k++)
      if (s1.sel[k]) acc = acc | (SHIFT_W'({1'b1, s1.frac}) << k);
  end

  always_comb begin
    prod_d = acc[FRAC_W +: PROD_W];
    sat_d  = 1'b0;
    if (s1.zero) begin
      prod_d = '0;
    end else if (s1.sat) begin
      prod_d = SAT_VAL;
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      out_prod <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1.sel  <= sel_d;
          s1.frac <= in_frac;
          s1.zero <= in_zero;
          s1.sat  <= SAT_EN && !in_zero && (in_char == CHAR_W'(CHAR_SAT));
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_prod <= prod_d;
          out_sat  <= sat_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_antilog_decode.sv
// Scoreboard bench for antilog_decode: both SAT_EN settings side by side, arithmetic reference.
module tb_antilog_decode;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_zero = 1'b0, out_ready = 1'b0;
  logic [4:0]  in_char = '0;
  logic [14:0] in_frac = '0;
  logic        in_ready, in_ready0, out_valid, out_valid0, out_sat, out_sat0;
  logic [31:0] out_prod, out_prod0;

  always #5 clk = ~clk;

  antilog_decode #(.SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_frac(in_frac), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_sat(out_sat));

  antilog_decode #(.SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_char(in_char), .in_frac(in_frac), .in_zero(in_zero),
    .out_valid(out_valid0), .out_ready(out_ready), .out_prod(out_prod0), .out_sat(out_sat0));

  typedef struct {
    logic [31:0] p1; logic s1;
    logic [31:0] p0; logic s0;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, acc_cnt = 0, emit_cnt = 0;
  bit chk_rdy = 1'b0, rst_edge = 1'b1;

  // Product = (1.frac) * 2^char, truncated to an integer.
  function automatic void ref_model(input int ch, input int frac, input bit zero, input bit sat_en,
                                    output logic [31:0] p, output logic s);
    longint v;
    p = '0; s = 1'b0;
    if (zero) return;
    if (ch == 31) begin
      if (sat_en) begin p = 32'hFFFF_FFFF; s = 1'b1; end
      return;
    end
    v = (longint'(32768 + frac) * (longint'(1) << ch)) / 32768;
    p = v[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_edge = !rst_n;

  // Stimulus side: an accepted operand pushes its expected results.
  always @(negedge clk) begin : pusher
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      ref_model(in_char, in_frac, in_zero, 1'b1, e.p1, e.s1);
      ref_model(in_char, in_frac, in_zero, 1'b0, e.p0, e.s0);
      sb.push_back(e);
      acc_cnt++;
    end
  end

  // Monitor: pop on each emitted result; also check stall stability.
  bit          stall_prev = 1'b0;
  logic [31:0] held_p;
  logic        held_s;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      check("out_valid_sat0", out_valid0, 1);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected none", out_prod);
      end else begin
        e = sb.pop_front();
        check("prod_sat1", out_prod, e.p1);
        check("sat_sat1", out_sat, e.s1);
        check("prod_sat0", out_prod0, e.p0);
        check("sat_sat0", out_sat0, e.s0);
      end
      emit_cnt++;
    end
    if (stall_prev && !rst_edge) begin
      check("stall_prod", out_prod, held_p);
      check("stall_sat", out_sat, held_s);
    end
    stall_prev = rst_n && out_valid && !out_ready;
    held_p = out_prod;
    held_s = out_sat;
  end

  // in_ready from occupancy: full pipe only accepts when the output drains.
  always @(posedge clk) if (chk_rdy) begin
    #2;
    check("in_ready", in_ready, 32'(((acc_cnt - emit_cnt) < 2) || out_ready));
    check("in_ready_sat0", in_ready0, 32'(((acc_cnt - emit_cnt) < 2) || out_ready));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int ch, input int frac, input bit zero);
    in_char = 5'(ch); in_frac = 15'(frac); in_zero = zero;
  endtask

  initial begin
    int sent, cyc, emit0;
    bit saw_block;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prod", out_prod, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_valid_sat0", out_valid0, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    chk_rdy = 1'b1;

    // Latency: char 4, frac 0x4000 -> 0x18 two edges after accept
    out_ready = 1'b1;
    drive(4, 15'h4000, 0); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("lat_cycle1_valid", out_valid, 0);
    tick();
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_prod", out_prod, 32'h0000_0018);
    check("lat_sat", out_sat, 0);
    repeat (3) tick();

    // Boundary operands, back-to-back
    in_valid = 1'b1;
    drive(0, 15'h7FFF, 0);  tick();
    drive(30, 15'h7FFF, 0); tick();
    drive(31, 15'h1234, 0); tick();
    drive(31, 15'h1234, 1); tick();
    drive(17, 15'h5555, 1); tick();
    drive(15, 15'h0000, 0); tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // 8-operand stream with out_ready low during cycles 3..5
    sent = 0; saw_block = 1'b0; emit0 = emit_cnt;
    for (cyc = 0; sent < 8 && cyc < 100; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = 1'b1;
      drive(sent * 3 + 1, 1000 * sent + 7, 0);
      #1;
      if (!in_ready) saw_block = 1'b1;
      else sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("stream_blocked", 32'(saw_block), 1);
    check("stream_emitted", 32'(emit_cnt - emit0), 8);

    // Reset with both stages full: nothing pre-reset may come out
    out_ready = 1'b0; in_valid = 1'b1;
    drive(9, 15'h0F0F, 0); tick();
    drive(10, 15'h7000, 0); tick();
    drive(11, 15'h0001, 0); tick();
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    sb.delete(); acc_cnt = 0; emit_cnt = 0;
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    check("midrst_no_stale", 32'(emit_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 31), $urandom_range(0, 32767), $urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin tick(); cyc++; end
    check("drain_empty", 32'(sb.size()), 0);
    check("drain_balance", 32'(acc_cnt - emit_cnt), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
